button_event_arbiter: RTL and testbench



---
 rtl/button_pkg.sv | 18 +
 rtl/tick_gen.sv | 32 +++
 rtl/button_event_arbiter.sv | 129 ++++++++++++
 tb/tb_button_event_arbiter.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared state encoding and defaults for the front-panel button event arbiter
// and its millisecond prescaler.
package button_pkg;

    typedef enum logic [1:0] {
        ST_DISABLED = 2'd0,
        ST_WARMUP   = 2'd1,
        ST_RUN      = 2'd2
    } btn_state_t;

    localparam int TICK_HZ_DEF    = 1000;
    localparam int WARM_TICKS_DEF = 16;

    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle registered tick every DIV clocks while run=1.
// Dropping run parks the counter at 0 so the next tick lands DIV cycles after run rises.
module tick_gen #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam int CW = (DIV <= 2) ? 1 : $clog2(DIV);

    logic [CW-1:0] r_cnt;
    logic          r_tick;

    always_ff @(posedge clk) begin
        if (!rst || !run) begin
            r_cnt  <= '0;
            r_tick <= 1'b0;
        end else if (r_cnt == CW'(DIV - 1)) begin
            r_cnt  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_tick <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule

// File: rtl/button_event_arbiter.sv
// Front-panel debounce controller: drives the shared ms tick and debouncer reset,
// latches release pulses and serialises them round-robin onto one valid/ready port.
module button_event_arbiter
    import button_pkg::*;
#(
    parameter  int N_BTN      = 4,
    parameter  int CLK_HZ     = 50000000,
    parameter  int TICK_HZ    = TICK_HZ_DEF,
    parameter  int WARM_TICKS = WARM_TICKS_DEF,
    localparam int ID_W       = id_width(N_BTN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [N_BTN-1:0] db_pulse,
    output logic             m_f,
    output logic             db_rst,
    output logic             evt_valid,
    output logic [ID_W-1:0]  evt_id,
    input  logic             evt_ready,
    output logic [N_BTN-1:0] overrun,
    input  logic             clr_overrun
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;

    btn_state_t       r_state, w_state_nxt;
    logic [7:0]       r_warm, w_warm_nxt;
    logic [N_BTN-1:0] r_pend, r_ovr;
    logic [ID_W-1:0]  r_ptr, r_id;
    logic             r_valid, r_db_rst;

    logic             w_tick, w_run, w_cap;
    logic             w_gnt_any, w_gnt_ok;
    logic [ID_W-1:0]  w_gnt_id;
    logic [N_BTN-1:0] w_gnt_mask, w_ovr_set;

    function automatic logic [ID_W-1:0] wrap_idx(input int v);
        return ID_W'((v >= N_BTN) ? v - N_BTN : v);
    endfunction

    // Gating with en keeps m_f quiet on the edge that drops back to DISABLED.
    assign w_run = (r_state != ST_DISABLED) && en;

    tick_gen #(.DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .run  (w_run),
        .tick (w_tick)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_warm_nxt  = r_warm;
        unique case (r_state)
            ST_DISABLED: begin
                if (en) begin
                    w_state_nxt = ST_WARMUP;
                    w_warm_nxt  = '0;
                end
            end
            ST_WARMUP: begin
                if (!en) begin
                    w_state_nxt = ST_DISABLED;
                end else if (w_tick) begin
                    w_warm_nxt = r_warm + 8'd1;
                    if (r_warm + 8'd1 == 8'(WARM_TICKS))
                        w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!en)
                    w_state_nxt = ST_DISABLED;
            end
            default: w_state_nxt = ST_DISABLED;
        endcase
    end

    // First pending bit at or after the pointer, wrapping.
    always_comb begin
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < N_BTN; k++) begin
            if (!w_gnt_any && r_pend[wrap_idx(int'(r_ptr) + k)]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = wrap_idx(int'(r_ptr) + k);
            end
        end
    end

    assign w_gnt_ok   = (r_state == ST_RUN) && (!r_valid || evt_ready) && w_gnt_any;
    assign w_gnt_mask = w_gnt_ok ? ({{(N_BTN-1){1'b0}}, 1'b1} << w_gnt_id) : '0;
    assign w_cap      = (r_state == ST_RUN) && en;
    assign w_ovr_set  = w_cap ? (db_pulse & r_pend & ~w_gnt_mask) : '0;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_DISABLED;
            r_warm   <= '0;
            r_pend   <= '0;
            r_ptr    <= '0;
            r_valid  <= 1'b0;
            r_id     <= '0;
            r_db_rst <= 1'b1;
            r_ovr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_warm   <= w_warm_nxt;
            r_db_rst <= (r_state == ST_DISABLED);
            // A granted bit re-arms if its own pulse arrives in the same cycle.
            r_pend   <= w_cap ? ((r_pend & ~w_gnt_mask) | db_pulse) : '0;
            r_ovr    <= (r_ovr & ~{N_BTN{clr_overrun}}) | w_ovr_set;
            if (w_gnt_ok) begin
                r_valid <= 1'b1;
                r_id    <= w_gnt_id;
                r_ptr   <= wrap_idx(int'(w_gnt_id) + 1);
            end else if (evt_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign m_f       = w_tick;
    assign db_rst    = r_db_rst;
    assign evt_valid = r_valid;
    assign evt_id    = r_id;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: reset/warm-up vector table, directed corner
// sequences, then random traffic, all shadowed by a cycle-level reference model.
module tb_button_event_arbiter;

    localparam int N    = 4;
    localparam int DIV  = 4;
    localparam int WARM = 2;
    localparam int NV   = 17;

    logic       clk = 1'b0;
    logic       rst, en, evt_ready, clr_overrun;
    logic [3:0] db_pulse;
    logic       m_f, db_rst, evt_valid;
    logic [1:0] evt_id;
    logic [3:0] overrun;

    int n_cmp = 0;
    int n_bad = 0;

    button_event_arbiter #(
        .N_BTN(N), .CLK_HZ(DIV), .TICK_HZ(1), .WARM_TICKS(WARM)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .db_pulse(db_pulse),
        .m_f(m_f), .db_rst(db_rst), .evt_valid(evt_valid), .evt_id(evt_id),
        .evt_ready(evt_ready), .overrun(overrun), .clr_overrun(clr_overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    // Reference model: phases 0=off 1=warm 2=run, tick derived from cycles since enable.
    int m_phase = 0, m_cyc = 0, m_ticks = 0, m_ptr = 0, m_id = 0;
    bit m_valid = 0, m_mf = 0, m_dbr = 1;
    bit m_pend[N];
    bit m_ovr[N];

    always @(posedge clk) begin
        int gnt, nphase;
        bit live, cap, nmf;
        if (!rst) begin
            m_phase = 0; m_cyc = 0; m_ticks = 0; m_ptr = 0; m_id = 0;
            m_valid = 0; m_mf = 0; m_dbr = 1;
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_ovr[i] = 0; end
        end else begin
            live = (m_phase != 0) && en;
            cap  = (m_phase == 2) && en;
            gnt  = -1;
            if (m_phase == 2 && (!m_valid || evt_ready))
                for (int k = 0; k < N; k++)
                    if (gnt < 0 && m_pend[(m_ptr + k) % N]) gnt = (m_ptr + k) % N;
            for (int i = 0; i < N; i++) begin
                if (cap && db_pulse[i] && m_pend[i] && i != gnt) m_ovr[i] = 1;
                else if (clr_overrun) m_ovr[i] = 0;
                m_pend[i] = cap && (db_pulse[i] || (m_pend[i] && i != gnt));
            end
            if (gnt >= 0) begin
                m_valid = 1; m_id = gnt; m_ptr = (gnt + 1) % N;
            end else if (evt_ready) begin
                m_valid = 0;
            end
            nphase = m_phase;
            case (m_phase)
                0: if (en) begin nphase = 1; m_ticks = 0; end
                1: if (!en) nphase = 0;
                   else if (m_mf) begin
                       m_ticks++;
                       if (m_ticks == WARM) nphase = 2;
                   end
                default: if (!en) nphase = 0;
            endcase
            nmf   = live && ((m_cyc + 1) % DIV == 0);
            m_cyc = live ? m_cyc + 1 : 0;
            m_dbr = (m_phase == 0);
            m_mf  = nmf;
            m_phase = nphase;
        end
    end

    function automatic logic [3:0] m_ovr_vec();
        logic [3:0] v = '0;
        for (int i = 0; i < N; i++) v[i] = m_ovr[i];
        return v;
    endfunction

    always @(negedge clk) begin
        chk("mdl_m_f", m_f, m_mf);
        chk("mdl_db_rst", db_rst, m_dbr);
        chk("mdl_evt_valid", evt_valid, m_valid);
        if (m_valid) chk("mdl_evt_id", evt_id, m_id);
        chk("mdl_overrun", overrun, m_ovr_vec());
    end

    typedef struct {
        logic       rst, en;
        logic [3:0] pulse;
        logic       mf, dbr, vld;
        logic [1:0] id;
    } vec_t;

    vec_t tbl[NV];

    function automatic vec_t mk(logic r, logic e, logic [3:0] p, logic f, logic d, logic v, logic [1:0] i);
        vec_t t;
        t.rst = r; t.en = e; t.pulse = p; t.mf = f; t.dbr = d; t.vld = v; t.id = i;
        return t;
    endfunction

    task automatic ev(input string nm, input logic v, input logic [1:0] id);
        chk({nm, "_valid"}, evt_valid, v);
        if (v) chk({nm, "_id"}, evt_id, id);
    endtask

    initial begin
        rst = 0; en = 0; db_pulse = 0; evt_ready = 1; clr_overrun = 0;

        // rst en pulse | m_f db_rst valid id  (outputs after the edge)
        tbl[0]  = mk(0, 0, 4'b0000, 0, 1, 0, 0);
        tbl[1]  = mk(0, 0, 4'b0000, 0, 1, 0, 0);
        tbl[2]  = mk(0, 1, 4'b0000, 0, 1, 0, 0);
        tbl[3]  = mk(1, 1, 4'b0000, 0, 1, 0, 0);
        tbl[4]  = mk(1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[5]  = mk(1, 1, 4'b1111, 0, 0, 0, 0);
        tbl[6]  = mk(1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[7]  = mk(1, 1, 4'b1111, 1, 0, 0, 0);
        tbl[8]  = mk(1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[9]  = mk(1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[10] = mk(1, 1, 4'b0000, 0, 0, 0, 0);
        tbl[11] = mk(1, 1, 4'b0000, 1, 0, 0, 0);
        tbl[12] = mk(1, 1, 4'b0001, 0, 0, 0, 0);
        tbl[13] = mk(1, 1, 4'b0100, 0, 0, 0, 0);
        tbl[14] = mk(1, 1, 4'b0000, 0, 0, 1, 2);
        tbl[15] = mk(1, 1, 4'b0000, 1, 0, 0, 2);
        tbl[16] = mk(1, 1, 4'b0000, 0, 0, 0, 2);

        for (int r = 0; r < NV; r++) begin
            rst = tbl[r].rst; en = tbl[r].en; db_pulse = tbl[r].pulse;
            step(1);
            chk($sformatf("v%0d_m_f", r), m_f, tbl[r].mf);
            chk($sformatf("v%0d_db_rst", r), db_rst, tbl[r].dbr);
            chk($sformatf("v%0d_valid", r), evt_valid, tbl[r].vld);
            chk($sformatf("v%0d_id", r), evt_id, tbl[r].id);
            chk($sformatf("v%0d_overrun", r), overrun, 4'b0000);
        end

        // Round robin: park pointer at 0, then all four, then 1 and 3.
        db_pulse = 4'b1000; step(1); db_pulse = 0;
        step(1); ev("rr_park", 1, 3);
        step(1); ev("rr_park_done", 0, 0);
        db_pulse = 4'b1111; step(1); db_pulse = 0;
        for (int i = 0; i < 4; i++) begin
            step(1); ev($sformatf("rr_all%0d", i), 1, 2'(i));
        end
        step(1); ev("rr_all_done", 0, 0);
        db_pulse = 4'b1010; step(1); db_pulse = 0;
        step(1); ev("rr_wrap_a", 1, 1);
        step(1); ev("rr_wrap_b", 1, 3);
        step(1); ev("rr_wrap_done", 0, 0);

        // Backpressure: slot holds id 1, second pulse pends, third overruns.
        evt_ready = 0;
        db_pulse = 4'b0010; step(1); db_pulse = 0;
        step(1); ev("bp_slot", 1, 1);
        step(3);
        db_pulse = 4'b0010; step(1); db_pulse = 0;
        chk("bp_no_ovr_yet", overrun, 4'b0000);
        step(4);
        db_pulse = 4'b0010; step(1); db_pulse = 0;
        chk("bp_ovr_set", overrun, 4'b0010);
        step(2); ev("bp_hold", 1, 1);
        evt_ready = 1;
        step(1); ev("bp_one_more", 1, 1);
        step(1); ev("bp_drained", 0, 0);
        chk("bp_ovr_sticky", overrun, 4'b0010);
        clr_overrun = 1; step(1); clr_overrun = 0;
        chk("bp_ovr_clr", overrun, 4'b0000);

        // Grant and pulse on the same bit in the same cycle.
        db_pulse = 4'b0001; step(1);
        step(1); db_pulse = 0; ev("sim_first", 1, 0);
        chk("sim_no_ovr", overrun, 4'b0000);
        step(1); ev("sim_second", 1, 0);
        step(1); ev("sim_done", 0, 0);

        // Disable with a held slot and two pending events.
        evt_ready = 0;
        db_pulse = 4'b0001; step(1);
        db_pulse = 4'b0110; step(1); db_pulse = 0;
        ev("dis_slot", 1, 0);
        en = 0; step(1); ev("dis_held", 1, 0);
        step(1); chk("dis_db_rst", db_rst, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk($sformatf("dis_m_f%0d", i), m_f, 1'b0);
            ev($sformatf("dis_hold%0d", i), 1, 0);
        end
        evt_ready = 1; step(1); ev("dis_accept", 0, 0);
        step(3); ev("dis_quiet", 0, 0);

        en = 1; step(12);

        for (int c = 0; c < 3000; c++) begin
            rst         = ($urandom_range(0, 499) != 0);
            en          = ($urandom_range(0, 299) != 0);
            evt_ready   = ($urandom_range(0, 3) != 0);
            clr_overrun = ($urandom_range(0, 31) == 0);
            for (int i = 0; i < N; i++) db_pulse[i] = ($urandom_range(0, 7) == 0);
            step(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
